alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue.sv | 166 ++++++++++++++++
 tb/tb_alu_issue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Issue-side and ALU-side signals of alu_issue, grouped as one bundle.
// The slave modport is the issue block; the master is the requester plus external ALU.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output in_valid, opcode, funct, op_a, op_b, alu_out, alu_z, out_ready,
    input  in_ready, ctl, alu_a, alu_b, out_valid, result, zero, err, hi, lo
  );
  modport slave (
    input  in_valid, opcode, funct, op_a, op_b, alu_out, alu_z, out_ready,
    output in_ready, ctl, alu_a, alu_b, out_valid, result, zero, err, hi, lo
  );
endinterface

// File: rtl/alu_issue.sv
// MIPS ALU issue stage: decodes ops to an external ALU, and runs iterative
// shift-add multiply / restoring divide into HI/LO.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  io
);
  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100,
                         C_XOR = 4'b1101;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
  typedef enum logic [2:0] {K_ALU, K_MUL, K_DIV, K_MFHI, K_MFLO, K_BAD} kind_t;

  state_t      state_q;
  logic [3:0]  ctl_q;
  logic [31:0] alu_a_q, alu_b_q, result_q, hi_q, lo_q, opnd_q, a_q;
  logic        zero_q, err_q, neg_q, rneg_q, dz_q;
  logic [4:0]  cnt_q;
  logic [63:0] work_q;

  kind_t       dec_kind;
  logic [3:0]  dec_ctl;
  logic        dec_sgn;

  always_comb begin
    dec_kind = K_BAD;
    dec_ctl  = C_ADD;
    dec_sgn  = 1'b0;
    if (io.opcode == 6'h00) begin
      case (io.funct)
        6'h20, 6'h21: begin dec_kind = K_ALU; dec_ctl = C_ADD; end
        6'h22, 6'h23: begin dec_kind = K_ALU; dec_ctl = C_SUB; end
        6'h24:        begin dec_kind = K_ALU; dec_ctl = C_AND; end
        6'h25:        begin dec_kind = K_ALU; dec_ctl = C_OR;  end
        6'h26:        begin dec_kind = K_ALU; dec_ctl = C_XOR; end
        6'h27:        begin dec_kind = K_ALU; dec_ctl = C_NOR; end
        6'h2A:        begin dec_kind = K_ALU; dec_ctl = C_SLT; end
        6'h18:        begin dec_kind = K_MUL; dec_sgn = 1'b1; end
        6'h19:        dec_kind = K_MUL;
        6'h1A:        begin dec_kind = K_DIV; dec_sgn = 1'b1; end
        6'h1B:        dec_kind = K_DIV;
        6'h10:        dec_kind = K_MFHI;
        6'h12:        dec_kind = K_MFLO;
        default:      dec_kind = K_BAD;
      endcase
    end else begin
      case (io.opcode)
        6'h08, 6'h09: begin dec_kind = K_ALU; dec_ctl = C_ADD; end
        6'h0A:        begin dec_kind = K_ALU; dec_ctl = C_SLT; end
        6'h0C:        begin dec_kind = K_ALU; dec_ctl = C_AND; end
        6'h0D:        begin dec_kind = K_ALU; dec_ctl = C_OR;  end
        6'h0E:        begin dec_kind = K_ALU; dec_ctl = C_XOR; end
        6'h04, 6'h05: begin dec_kind = K_ALU; dec_ctl = C_SUB; end
        default:      dec_kind = K_BAD;
      endcase
    end
  end

  // Iterate on magnitudes; signs are applied once on the final iteration.
  logic [31:0] a_abs, b_abs;
  assign a_abs = (dec_sgn && io.op_a[31]) ? -io.op_a : io.op_a;
  assign b_abs = (dec_sgn && io.op_b[31]) ? -io.op_b : io.op_b;

  logic [32:0] mul_sum, div_sh, div_diff;
  logic [63:0] mul_d, div_d, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_d    = {mul_sum, work_q[31:1]};
  assign div_sh   = {work_q[63:32], work_q[31]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_d    = div_diff[32] ? {div_sh[31:0], work_q[30:0], 1'b0}
                                 : {div_diff[31:0], work_q[30:0], 1'b1};
  assign prod_fix = neg_q  ? -mul_d : mul_d;
  assign quo_fix  = neg_q  ? -div_d[31:0]  : div_d[31:0];
  assign rem_fix  = rneg_q ? -div_d[63:32] : div_d[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctl_q    <= C_ADD;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          err_q <= 1'b0;
          cnt_q <= '0;
          case (dec_kind)
            K_ALU: begin
              ctl_q <= dec_ctl; alu_a_q <= io.op_a; alu_b_q <= io.op_b; state_q <= EXEC;
            end
            K_MUL: begin
              opnd_q  <= a_abs;
              work_q  <= {32'd0, b_abs};
              neg_q   <= dec_sgn & (io.op_a[31] ^ io.op_b[31]);
              state_q <= MUL;
            end
            K_DIV: begin
              opnd_q  <= b_abs;
              work_q  <= {32'd0, a_abs};
              neg_q   <= dec_sgn & (io.op_a[31] ^ io.op_b[31]);
              rneg_q  <= dec_sgn & io.op_a[31];
              dz_q    <= (io.op_b == '0);
              a_q     <= io.op_a;
              state_q <= DIV;
            end
            K_MFHI: begin result_q <= hi_q; zero_q <= (hi_q == '0); state_q <= DONE; end
            K_MFLO: begin result_q <= lo_q; zero_q <= (lo_q == '0); state_q <= DONE; end
            default: begin
              err_q <= 1'b1; result_q <= '0; zero_q <= 1'b1; state_q <= DONE;
            end
          endcase
        end
        EXEC: begin
          result_q <= io.alu_out;
          zero_q   <= io.alu_z;
          state_q  <= DONE;
        end
        MUL: begin
          work_q <= mul_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            {hi_q, lo_q} <= prod_fix;
            result_q <= '0; zero_q <= 1'b1; state_q <= DONE;
          end
        end
        DIV: begin
          work_q <= div_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // Divide by zero still spends the full 32 iterations, then overrides.
            hi_q <= dz_q ? a_q : rem_fix;
            lo_q <= dz_q ? 32'hFFFF_FFFF : quo_fix;
            result_q <= '0; zero_q <= 1'b1; state_q <= DONE;
          end
        end
        DONE: if (io.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.ctl       = ctl_q;
  assign io.alu_a     = alu_a_q;
  assign io.alu_b     = alu_b_q;
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.err       = err_q;
  assign io.hi        = hi_q;
  assign io.lo        = lo_q;
endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue with an external ALU model and
// an opcode-level reference model.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_issue_if io ();

  alu_issue dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  // External ALU, keyed on the control code.
  always_comb begin
    case (io.ctl)
      4'b0010: io.alu_out = io.alu_a + io.alu_b;
      4'b0110: io.alu_out = io.alu_a - io.alu_b;
      4'b0000: io.alu_out = io.alu_a & io.alu_b;
      4'b0001: io.alu_out = io.alu_a | io.alu_b;
      4'b1101: io.alu_out = io.alu_a ^ io.alu_b;
      4'b1100: io.alu_out = ~(io.alu_a | io.alu_b);
      4'b0111: io.alu_out = ($signed(io.alu_a) < $signed(io.alu_b)) ? 32'd1 : 32'd0;
      default: io.alu_out = '0;
    endcase
    io.alu_z = (io.alu_out == '0);
  end

  int n_chk = 0, n_pass = 0;
  logic [31:0] mhi, mlo, malu_a, malu_b;
  logic [3:0]  mctl;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    mhi = '0; mlo = '0; malu_a = '0; malu_b = '0; mctl = 4'b0010;
  endtask

  // Reference: k = 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 mult,8 multu,
  // 9 div,10 divu,11 mfhi,12 mflo,-1 unsupported.
  task automatic ref_op(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic e,
                        output int lat);
    int k;
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] up;
    k = -1;
    if (opc == 6'h00) begin
      case (fn)
        6'h20, 6'h21: k = 0;  6'h22, 6'h23: k = 1;  6'h24: k = 2;  6'h25: k = 3;
        6'h26: k = 4;  6'h27: k = 5;  6'h2A: k = 6;  6'h18: k = 7;  6'h19: k = 8;
        6'h1A: k = 9;  6'h1B: k = 10; 6'h10: k = 11; 6'h12: k = 12;
        default: k = -1;
      endcase
    end else begin
      case (opc)
        6'h08, 6'h09: k = 0;  6'h0A: k = 6;  6'h0C: k = 2;  6'h0D: k = 3;
        6'h0E: k = 4;  6'h04, 6'h05: k = 1;
        default: k = -1;
      endcase
    end
    sa = $signed(a); sb = $signed(b);
    res = '0; z = 1'b1; e = 1'b0; lat = 33;
    case (k)
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = ~(a | b);
      6: res = (sa < sb) ? 32'd1 : 32'd0;
      7: begin up = sa * sb; {mhi, mlo} = up; end
      8: begin up = {32'd0, a} * {32'd0, b}; {mhi, mlo} = up; end
      9: if (b == 0) begin mhi = a; mlo = '1; end
         else begin sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0]; end
      10: if (b == 0) begin mhi = a; mlo = '1; end
          else begin mlo = a / b; mhi = a % b; end
      11: res = mhi;
      12: res = mlo;
      default: e = 1'b1;
    endcase
    if (k >= 0 && k <= 6) begin
      lat = 2; z = (res == 0); malu_a = a; malu_b = b;
      case (k)
        0: mctl = 4'b0010; 1: mctl = 4'b0110; 2: mctl = 4'b0000; 3: mctl = 4'b0001;
        4: mctl = 4'b1101; 5: mctl = 4'b1100; default: mctl = 4'b0111;
      endcase
    end else if (k == 11 || k == 12) begin
      lat = 1; z = (res == 0);
    end else if (k < 0) begin
      lat = 1;
    end
  endtask

  // One request/response transaction; out_ready held low for 'hold' cycles.
  task automatic do_op(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er; logic ez, ee; int elat, lat;
    ref_op(opc, fn, a, b, er, ez, ee, elat);
    @(negedge clk);
    chk("in_ready_idle", io.in_ready, 1);
    io.opcode = opc; io.funct = fn; io.op_a = a; io.op_b = b; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("lat op%0h/%0h", opc, fn), lat, elat);
    chk("result", io.result, er);
    chk("zero", io.zero, ez);
    chk("err", io.err, ee);
    chk("hi", io.hi, mhi);
    chk("lo", io.lo, mlo);
    chk("ctl", io.ctl, mctl);
    chk("alu_a", io.alu_a, malu_a);
    chk("alu_b", io.alu_b, malu_b);
    chk("no_ready_in_done", io.in_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", io.out_valid, 1);
      chk("hold_result", {io.result, io.zero, io.err}, {er, ez, ee});
      chk("hold_ready", io.in_ready, 0);
    end
    @(negedge clk); io.out_ready = 1'b1;
    @(posedge clk); #1; io.out_ready = 1'b0;
    chk("back_idle", {io.out_valid, io.in_ready}, 2'b01);
  endtask

  logic [11:0] ops [15] = '{
    {6'h00, 6'h20}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h26}, {6'h00, 6'h27},
    {6'h00, 6'h2A}, {6'h0A, 6'h00}, {6'h0D, 6'h00}, {6'h00, 6'h18}, {6'h00, 6'h19},
    {6'h00, 6'h1A}, {6'h00, 6'h1B}, {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h3F, 6'h00}
  };

  initial begin
    logic [11:0] op;
    logic [31:0] ra, rb;
    io.in_valid = 1'b0; io.out_ready = 1'b0; io.opcode = '0; io.funct = '0;
    io.op_a = '0; io.op_b = '0;
    model_reset();
    #12;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_regs", {io.result, io.zero, io.err, io.hi, io.lo}, '0);
    chk("rst_alu", {io.ctl, io.alu_a, io.alu_b}, {4'b0010, 64'd0});
    @(negedge clk); rst_n = 1'b1;
    chk("rst_in_ready", io.in_ready, 1);

    do_op(6'h00, 6'h22, 32'd15, 32'd126, 0);
    do_op(6'h00, 6'h2A, 32'd100000, 32'd10001, 0);
    do_op(6'h00, 6'h2A, 32'd10001, 32'd100000, 0);
    do_op(6'h00, 6'h27, 32'd15, 32'd126, 0);
    do_op(6'h00, 6'h18, 32'hFFFF_FFFE, 32'd3, 0);
    do_op(6'h00, 6'h19, 32'hFFFF_FFFE, 32'd3, 0);
    do_op(6'h00, 6'h1A, -32'sd7, 32'd2, 0);
    do_op(6'h00, 6'h12, 32'd0, 32'd0, 0);
    do_op(6'h00, 6'h10, 32'd0, 32'd0, 0);
    do_op(6'h00, 6'h1B, 32'd7, 32'd0, 0);
    do_op(6'h00, 6'h12, 32'd0, 32'd0, 0);
    do_op(6'h00, 6'h10, 32'd0, 32'd0, 0);
    do_op(6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(6'h00, 6'h1A, 32'd9, 32'd0, 0);
    do_op(6'h00, 6'h20, 32'd5, 32'hFFFF_FFFB, 5);

    // Abort a multiply part way through with an asynchronous reset.
    @(negedge clk);
    io.opcode = 6'h00; io.funct = 6'h18; io.op_a = 32'd1234; io.op_b = 32'd5678;
    io.in_valid = 1'b1;
    @(posedge clk); #1; io.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_mul_hilo", {io.hi, io.lo}, {mhi, mlo});
    rst_n = 1'b0; #1;
    model_reset();
    chk("abort_valid", io.out_valid, 0);
    chk("abort_regs", {io.result, io.zero, io.err, io.hi, io.lo}, '0);
    chk("abort_alu", {io.ctl, io.alu_a, io.alu_b}, {4'b0010, 64'd0});
    @(negedge clk); rst_n = 1'b1;
    do_op(6'h00, 6'h20, 32'd1, 32'd2, 0);
    do_op(6'h00, 6'h3F, 32'd1, 32'd2, 0);
    do_op(6'h08, 6'h00, 32'd0, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 14)];
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 4))
        0: begin ra = $urandom_range(0, 20); rb = $urandom_range(0, 20); end
        1: rb = '0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = ra;
        default: ;
      endcase
      do_op(op[11:6], op[5:0], ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
